// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types, constants and helpers for the instruction-memory
//               arbiter. It holds the default memory depth, the arbiter FSM
//               state type, a request bundle type, and a helper that decides
//               whether a byte address reaches a real memory word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Default instruction-memory depth in 32-bit words.
    localparam int unsigned IMEM_WORDS_DEFAULT = 1024;

    // Arbiter FSM states: ARB = normal arbitration, LOCKED = loader owns the
    // memory for a burst.
    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // One requester's view of an access.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } imem_req_t;

    // An access is legal only when it is word aligned and its word index is
    // inside the memory.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input int unsigned words);
        logic [31:0] w_word;
        w_word = {2'b00, addr[31:2]};
        return (addr[1:0] == 2'b00) && (w_word < words);
    endfunction

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_resp_reg.sv
`default_nettype none
// ============================================================================
// Module      : imem_resp_reg
// Description : Response register for one requester of the instruction-memory
//               arbiter. The cycle after a grant it pulses o_rvalid for one
//               cycle together with the captured read data (legal read), zero
//               data (legal write) or zero data plus o_err (illegal access).
//               o_rdata holds its last value while no response is pending.
// Ports       : clk         - clock
//               reset_n     - asynchronous active-low reset
//               i_gnt       - this requester is granted in the current cycle
//               i_legal     - the granted access hits a real memory word
//               i_we        - the granted access is a write
//               i_mem_rdata - combinational memory read data
//               o_rvalid    - response valid (one-cycle pulse)
//               o_rdata     - response data
//               o_err       - response error (qualified by o_rvalid)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_resp_reg
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_gnt,
    input  logic        i_legal,
    input  logic        i_we,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= i_gnt;
            r_err    <= i_gnt & ~i_legal;
            // Data only moves on a grant so it stays stable between responses.
            if (i_gnt) begin
                r_rdata <= (i_legal && !i_we) ? i_mem_rdata : 32'h0000_0000;
            end
        end
    end

    assign o_rvalid = r_rvalid;
    assign o_rdata  = r_rdata;
    assign o_err    = r_err;

endmodule : imem_resp_reg
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares a single-port instruction memory between the core fetch
//               port (read only) and the boot/debug loader port (read/write).
//               At most one access is granted per cycle; grants are
//               combinational. Fetch normally wins a contested cycle, but a
//               loader that has been refused STARVE_LIMIT times in a row wins
//               the next one. Boot mode serves the loader only, and a loader
//               grant with lock set keeps ownership until lock drops.
//               Responses come back one cycle after the grant.
// Ports       : clk, reset_n                       - clock, async active-low reset
//               boot_mode_i                        - serve loader only
//               fetch_req_i/addr_i                 - fetch request, byte address
//               fetch_gnt_o/rvalid_o/rdata_o/err_o - fetch grant and response
//               load_req_i/we_i/addr_i/wdata_i     - loader request
//               load_lock_i                        - loader burst ownership
//               load_gnt_o/rvalid_o/rdata_o/err_o  - loader grant and response
//               mem_req_o/we_o/addr_o/wdata_o      - memory access
//               mem_rdata_i                        - combinational memory data
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned IMEM_WORDS   = IMEM_WORDS_DEFAULT,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned IMEM_AW     = $clog2(IMEM_WORDS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               boot_mode_i,

    input  logic               fetch_req_i,
    input  logic [31:0]        fetch_addr_i,
    output logic               fetch_gnt_o,
    output logic               fetch_rvalid_o,
    output logic [31:0]        fetch_rdata_o,
    output logic               fetch_err_o,

    input  logic               load_req_i,
    input  logic               load_we_i,
    input  logic [31:0]        load_addr_i,
    input  logic [31:0]        load_wdata_i,
    input  logic               load_lock_i,
    output logic               load_gnt_o,
    output logic               load_rvalid_o,
    output logic [31:0]        load_rdata_o,
    output logic               load_err_o,

    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [IMEM_AW-1:0] mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    input  logic [31:0]        mem_rdata_i
);

    localparam int unsigned          c_CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0]   c_STARVE_MAX = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [c_CNT_W-1:0] r_starve_cnt;

    imem_req_t          w_fetch_req;
    imem_req_t          w_load_req;
    imem_req_t          w_sel_req;

    logic               w_fetch_gnt;
    logic               w_load_gnt;
    logic               w_any_gnt;
    logic               w_starved;
    logic               w_sel_legal;
    logic               w_mem_req;

    // ------------------------------------------------------------------------
    // Request bundles; the fetch port can never write.
    // ------------------------------------------------------------------------
    assign w_fetch_req = '{req: fetch_req_i, we: 1'b0,
                           addr: fetch_addr_i, wdata: 32'h0000_0000};
    assign w_load_req  = '{req: load_req_i, we: load_we_i,
                           addr: load_addr_i, wdata: load_wdata_i};

    assign w_starved   = (r_starve_cnt == c_STARVE_MAX);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Grant decision and next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_load_gnt  = 1'b0;
        w_state_nxt = r_state;

        case (r_state)
            ARB: begin
                if (boot_mode_i) begin
                    w_load_gnt = w_load_req.req;
                end else if (w_fetch_req.req && w_load_req.req) begin
                    // Fetch has priority until the loader has waited long enough.
                    if (w_starved) begin
                        w_load_gnt = 1'b1;
                    end else begin
                        w_fetch_gnt = 1'b1;
                    end
                end else begin
                    w_fetch_gnt = w_fetch_req.req;
                    w_load_gnt  = w_load_req.req;
                end

                if (w_load_gnt && load_lock_i) begin
                    w_state_nxt = LOCKED;
                end
            end

            LOCKED: begin
                // Burst ownership: loader only, boot mode irrelevant. Leaving
                // depends on lock alone, not on a request being present.
                w_load_gnt = w_load_req.req;
                if (!load_lock_i) begin
                    w_state_nxt = ARB;
                end
            end

            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Starvation counter: counts refused loader cycles, saturating.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_load_gnt) begin
            r_starve_cnt <= '0;
        end else if (load_req_i && !w_starved) begin
            r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side mux. Illegal requests are granted but never reach memory.
    // ------------------------------------------------------------------------
    assign w_sel_req   = w_load_gnt ? w_load_req : w_fetch_req;
    assign w_sel_legal = addr_legal(w_sel_req.addr, IMEM_WORDS);
    assign w_any_gnt   = w_fetch_gnt | w_load_gnt;
    assign w_mem_req   = w_any_gnt & w_sel_legal;

    assign mem_req_o   = w_mem_req;
    assign mem_we_o    = w_mem_req & w_sel_req.we;
    assign mem_addr_o  = w_sel_req.addr[IMEM_AW+1:2];
    assign mem_wdata_o = w_sel_req.wdata;

    assign fetch_gnt_o = w_fetch_gnt;
    assign load_gnt_o  = w_load_gnt;

    // ------------------------------------------------------------------------
    // Per-port response registers
    // ------------------------------------------------------------------------
    imem_resp_reg u_fetch_resp (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_gnt       (w_fetch_gnt),
        .i_legal     (w_sel_legal),
        .i_we        (1'b0),
        .i_mem_rdata (mem_rdata_i),
        .o_rvalid    (fetch_rvalid_o),
        .o_rdata     (fetch_rdata_o),
        .o_err       (fetch_err_o)
    );

    imem_resp_reg u_load_resp (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_gnt       (w_load_gnt),
        .i_legal     (w_sel_legal),
        .i_we        (load_we_i),
        .i_mem_rdata (mem_rdata_i),
        .o_rvalid    (load_rvalid_o),
        .o_rdata     (load_rdata_o),
        .o_err       (load_err_o)
    );

endmodule : imem_arbiter
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Self-checking bench for imem_arbiter. A behavioural model
//               (grant rules, a reference memory array, expected responses)
//               predicts every grant, memory strobe and response; directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int WORDS = 1024;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        boot_mode_i;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_gnt_o, fetch_rvalid_o, fetch_err_o;
    logic [31:0] fetch_rdata_o;
    logic        load_req_i, load_we_i, load_lock_i;
    logic [31:0] load_addr_i, load_wdata_i;
    logic        load_gnt_o, load_rvalid_o, load_err_o;
    logic [31:0] load_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    imem_arbiter #(.IMEM_WORDS(WORDS), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n), .boot_mode_i(boot_mode_i),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o),
        .fetch_rdata_o(fetch_rdata_o), .fetch_err_o(fetch_err_o),
        .load_req_i(load_req_i), .load_we_i(load_we_i), .load_addr_i(load_addr_i),
        .load_wdata_i(load_wdata_i), .load_lock_i(load_lock_i),
        .load_gnt_o(load_gnt_o), .load_rvalid_o(load_rvalid_o),
        .load_rdata_o(load_rdata_o), .load_err_o(load_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Environment memory (driven by the DUT) and reference memory (model).
    logic [31:0] ram     [WORDS];
    logic [31:0] ref_mem [WORDS];

    assign mem_rdata_i = mem_req_o ? ram[mem_addr_o] : 32'hA5A5_A5A5;

    // Reference model state
    bit          m_locked;
    int          m_starve;
    bit          exp_fv, exp_fe, exp_lv, exp_le;
    logic [31:0] exp_fd, exp_ld;

    // Observations from the last cycle
    bit          obs_fg, obs_lg, obs_mreq;
    logic [9:0]  obs_ma;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(WORDS));
    endfunction

    task automatic model_reset();
        m_locked = 0; m_starve = 0;
        exp_fv = 0; exp_fe = 0; exp_fd = '0;
        exp_lv = 0; exp_le = 0; exp_ld = '0;
    endtask

    // One clock cycle: inputs already applied at the falling edge.
    task automatic cycle();
        bit          ef, el, lg, we, lk, lreq, wr_en;
        logic [31:0] a, wd, wr_d;
        logic [9:0]  wr_a;
        #1;
        ef = 0; el = 0;
        if (m_locked || boot_mode_i) el = load_req_i;
        else if (fetch_req_i && load_req_i) begin
            if (m_starve == LIMIT) el = 1; else ef = 1;
        end else begin
            ef = fetch_req_i; el = load_req_i;
        end
        a    = el ? load_addr_i : fetch_addr_i;
        we   = el && load_we_i;
        wd   = load_wdata_i;
        lg   = legal(a);
        lk   = load_lock_i;
        lreq = load_req_i;

        check("fetch_gnt", 32'(fetch_gnt_o), 32'(ef));
        check("load_gnt",  32'(load_gnt_o),  32'(el));
        check("mem_req",   32'(mem_req_o),   32'((ef || el) && lg));
        if ((ef || el) && lg) begin
            check("mem_addr", 32'(mem_addr_o), a >> 2);
            check("mem_we",   32'(mem_we_o),   32'(we));
            if (we) check("mem_wdata", mem_wdata_o, wd);
        end
        obs_fg = fetch_gnt_o; obs_lg = load_gnt_o;
        obs_mreq = mem_req_o; obs_ma = mem_addr_o;
        wr_en = mem_req_o && mem_we_o; wr_a = mem_addr_o; wr_d = mem_wdata_o;

        @(posedge clk);
        if (wr_en) ram[wr_a] = wr_d;
        exp_fv = ef;
        if (ef) begin
            exp_fe = !lg;
            exp_fd = lg ? ref_mem[a[11:2]] : 32'h0;
        end
        exp_lv = el;
        if (el) begin
            exp_le = !lg;
            exp_ld = (lg && !we) ? ref_mem[a[11:2]] : 32'h0;
            if (lg && we) ref_mem[a[11:2]] = wd;
        end
        m_locked = lk && (m_locked || el);
        if (el) m_starve = 0;
        else if (lreq && m_starve < LIMIT) m_starve++;

        #1;
        check("fetch_rvalid", 32'(fetch_rvalid_o), 32'(exp_fv));
        check("fetch_rdata",  fetch_rdata_o, exp_fd);
        if (exp_fv) check("fetch_err", 32'(fetch_err_o), 32'(exp_fe));
        check("load_rvalid", 32'(load_rvalid_o), 32'(exp_lv));
        check("load_rdata",  load_rdata_o, exp_ld);
        if (exp_lv) check("load_err", 32'(load_err_o), 32'(exp_le));
        @(negedge clk);
    endtask

    task automatic idle();
        fetch_req_i = 0; load_req_i = 0; load_lock_i = 0; load_we_i = 0;
        cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = 32'($urandom_range(0, WORDS - 1)) << 2;
        case ($urandom_range(0, 9))
            0: r = r | 32'($urandom_range(1, 3));
            1: r = 32'($urandom_range(WORDS, 4 * WORDS)) << 2;
            2: r = $urandom & 32'hFFFF_FFFC;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int idx, guard;
        bit f_pend, l_pend;

        reset_n = 0; boot_mode_i = 0;
        fetch_req_i = 0; fetch_addr_i = '0;
        load_req_i = 0; load_we_i = 0; load_addr_i = '0; load_wdata_i = '0; load_lock_i = 0;
        for (int i = 0; i < WORDS; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[3] = 32'hDEAD_BEEF; ref_mem[3] = 32'hDEAD_BEEF;
        model_reset();

        // Reset values
        @(posedge clk); @(posedge clk); #1;
        check("rst_fetch_rvalid", 32'(fetch_rvalid_o), 0);
        check("rst_fetch_rdata",  fetch_rdata_o, 0);
        check("rst_fetch_err",    32'(fetch_err_o), 0);
        check("rst_load_rvalid",  32'(load_rvalid_o), 0);
        check("rst_load_rdata",   load_rdata_o, 0);
        check("rst_load_err",     32'(load_err_o), 0);
        @(negedge clk); reset_n = 1;

        // 1. Fetch only
        fetch_req_i = 1; fetch_addr_i = 32'h0C;
        cycle();
        check("t1_fgnt", 32'(obs_fg), 1);
        check("t1_maddr", 32'(obs_ma), 3);
        check("t1_rvalid", 32'(fetch_rvalid_o), 1);
        check("t1_rdata", fetch_rdata_o, 32'hDEAD_BEEF);
        check("t1_err", 32'(fetch_err_o), 0);
        idle();

        // 2. Contention / starvation
        load_req_i = 1; load_we_i = 0; load_addr_i = 32'h40; load_lock_i = 0;
        for (int n = 0; n < 6; n++) begin
            fetch_req_i = 1; fetch_addr_i = 32'(n * 4);
            cycle();
            check("t2_fgnt", 32'(obs_fg), 32'(n != 4));
            check("t2_lgnt", 32'(obs_lg), 32'(n == 4));
        end
        idle();

        // 3. Loader burst lock
        idx = 0; guard = 0;
        fetch_req_i = 1; fetch_addr_i = 32'h10;
        while (idx < 3 && guard < 20) begin
            load_req_i = 1; load_we_i = 1; load_lock_i = 1;
            load_addr_i = 32'(idx * 4); load_wdata_i = 32'(8'h11 * (idx + 1));
            cycle();
            if (obs_lg) idx++;
            guard++;
        end
        check("t3_writes_done", 32'(idx), 3);
        load_req_i = 0; load_we_i = 0; load_lock_i = 0;
        cycle();
        check("t3_fgnt_release", 32'(obs_fg), 0);
        cycle();
        check("t3_fgnt_after", 32'(obs_fg), 1);
        fetch_addr_i = 32'h04;
        cycle();
        check("t3_readback", fetch_rdata_o, 32'h22);
        idle();

        // 4. Illegal addresses
        fetch_req_i = 1; fetch_addr_i = 32'h02;
        cycle();
        check("t4_fgnt", 32'(obs_fg), 1);
        check("t4_fmreq", 32'(obs_mreq), 0);
        check("t4_ferr", 32'(fetch_err_o), 1);
        check("t4_frdata", fetch_rdata_o, 0);
        fetch_req_i = 0; load_req_i = 1; load_we_i = 0; load_addr_i = 32'h1000;
        cycle();
        check("t4_lgnt", 32'(obs_lg), 1);
        check("t4_lmreq", 32'(obs_mreq), 0);
        check("t4_lerr", 32'(load_err_o), 1);
        check("t4_lrdata", load_rdata_o, 0);
        idle();

        // 5. Boot mode
        boot_mode_i = 1; fetch_req_i = 1; fetch_addr_i = 32'h10;
        for (int n = 0; n < 6; n++) begin
            load_req_i = 1; load_we_i = 0; load_lock_i = 0; load_addr_i = 32'(n * 8);
            cycle();
            check("t5_lgnt", 32'(obs_lg), 1);
            check("t5_fgnt", 32'(obs_fg), 0);
        end
        boot_mode_i = 0;
        cycle();
        check("t5_fgnt_exit", 32'(obs_fg), 1);
        idle();

        // Randomized traffic, requests held until granted
        f_pend = 0; l_pend = 0;
        for (int n = 0; n < 600; n++) begin
            if (!f_pend && $urandom_range(0, 3) != 0) begin
                f_pend = 1; fetch_addr_i = rand_addr();
            end
            if (!l_pend && $urandom_range(0, 2) == 0) begin
                l_pend = 1; load_addr_i = rand_addr();
                load_we_i = 1'($urandom_range(0, 1)); load_wdata_i = $urandom;
            end
            fetch_req_i = f_pend; load_req_i = l_pend;
            load_lock_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0) boot_mode_i = !boot_mode_i;
            cycle();
            if (obs_fg) f_pend = 0;
            if (obs_lg) l_pend = 0;
        end
        boot_mode_i = 0;
        idle();

        // 6. Reset mid-access
        fetch_req_i = 0; load_req_i = 1; load_we_i = 0; load_lock_i = 1; load_addr_i = 32'h0;
        cycle();
        fetch_req_i = 1; fetch_addr_i = 32'h0C; load_addr_i = 32'h04;
        #1;
        check("t6_lgnt", 32'(load_gnt_o), 1);
        check("t6_fgnt", 32'(fetch_gnt_o), 0);
        #1 reset_n = 0;
        #1;
        check("t6_lrvalid", 32'(load_rvalid_o), 0);
        check("t6_lrdata",  load_rdata_o, 0);
        check("t6_lerr",    32'(load_err_o), 0);
        check("t6_frdata",  fetch_rdata_o, 0);
        fetch_req_i = 0; load_req_i = 0; load_lock_i = 0;
        @(posedge clk); #1;
        check("t6_no_lrvalid", 32'(load_rvalid_o), 0);
        check("t6_no_frvalid", 32'(fetch_rvalid_o), 0);
        @(negedge clk); reset_n = 1;
        model_reset();
        fetch_req_i = 1; fetch_addr_i = 32'h08; load_req_i = 1; load_addr_i = 32'h10;
        cycle();
        check("t6_arb_fgnt", 32'(obs_fg), 1);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imem_arbiter
`default_nettype wire
